// File: rtl/joystick_pkg.sv
// Shared constants for the joystick cursor engine: packet field layout,
// raw sample geometry and FSM state codes.
package joystick_pkg;

  localparam int PKT_W  = 40;
  localparam int RAW_W  = 10;
  localparam int CENTER = 512;
  localparam int BTN_W  = 3;

  // Packet layout {xlo, xhi, ylo, yhi, btn}
  localparam int X_LO_LSB = 32;
  localparam int X_HI_LSB = 24;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_LSB  = 0;

  // FSM state codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic [RAW_W-1:0] get_raw_x(input logic [PKT_W-1:0] p);
    return {p[X_HI_LSB +: 2], p[X_LO_LSB +: 8]};
  endfunction

  function automatic logic [RAW_W-1:0] get_raw_y(input logic [PKT_W-1:0] p);
    return {p[Y_HI_LSB +: 2], p[Y_LO_LSB +: 8]};
  endfunction

endpackage

// File: rtl/joy_axis.sv
// One cursor axis: deadzone/velocity decode, direction, fixed-point
// integrator with clamping to [0, MAX]. INVERT flips the direction so the
// y axis moves up the screen for positive deflection.
// Optional acceleration counter built when JOYSTICK_ACCEL_EN is defined.
module joy_axis
  import joystick_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int MAX         = 639,
  parameter int FRAC_BITS   = 4,
  parameter int DEADZONE    = 32,
  parameter int SPEED_SHIFT = 3,
`ifdef JOYSTICK_ACCEL_EN
  parameter int ACCEL_HOLD  = 16,
`endif
  parameter bit INVERT      = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               decode,
  input  logic               update,
  input  logic [RAW_W-1:0]   raw,
  output logic [COORD_W-1:0] coord,
  output logic [COORD_W-1:0] coord_next
);

  localparam int MAG_W = RAW_W - 1;
  localparam int POS_W = COORD_W + FRAC_BITS + 1;
  localparam logic signed [POS_W-1:0] MAX_POS   = POS_W'(MAX * (1 << FRAC_BITS));
  localparam logic [POS_W-2:0]        RESET_POS = (POS_W-1)'((MAX / 2) * (1 << FRAC_BITS));

  logic [MAG_W-1:0]        mag;
  logic [MAG_W-1:0]        v_base;
  logic [RAW_W-1:0]        v_apply;
  logic                    inc;
  logic [RAW_W-1:0]        v_q;
  logic                    inc_q;
  logic [POS_W-2:0]        pos;
  logic [POS_W-2:0]        pos_next;
  logic signed [POS_W-1:0] sum;

  // Deflection magnitude around center, velocity after deadzone and scaling
  always_comb begin
    if (raw >= RAW_W'(CENTER)) mag = MAG_W'(raw - RAW_W'(CENTER));
    else                       mag = MAG_W'(RAW_W'(CENTER - 1) - raw);
    if (mag < MAG_W'(DEADZONE)) v_base = '0;
    else                        v_base = (mag - MAG_W'(DEADZONE)) >> SPEED_SHIFT;
    inc = (raw >= RAW_W'(CENTER)) ^ INVERT;
  end

`ifdef JOYSTICK_ACCEL_EN
  localparam int CNT_W = $clog2(ACCEL_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_next;
  logic             last_act;
  logic             last_inc;

  // Sustained same-direction deflection counts up; anything else restarts it
  always_comb begin
    hold_next = '0;
    if (v_base != '0 && last_act && inc == last_inc) begin
      if (hold_cnt == CNT_W'(ACCEL_HOLD)) hold_next = hold_cnt;
      else                                hold_next = hold_cnt + 1'b1;
    end
    if (hold_next == CNT_W'(ACCEL_HOLD)) v_apply = {v_base, 1'b0};
    else                                 v_apply = {1'b0, v_base};
  end

  // Hold counter history advances once per decoded packet
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      last_act <= 1'b0;
      last_inc <= 1'b0;
    end else if (decode) begin
      hold_cnt <= hold_next;
      last_act <= (v_base != '0);
      last_inc <= inc;
    end
  end
`else
  assign v_apply = {1'b0, v_base};
`endif

  // Signed step, then clamp so the cursor never wraps
  always_comb begin
    if (inc_q) sum = signed'({1'b0, pos}) + signed'(POS_W'(v_q));
    else       sum = signed'({1'b0, pos}) - signed'(POS_W'(v_q));
    if (sum < 0)            pos_next = '0;
    else if (sum > MAX_POS) pos_next = MAX_POS[POS_W-2:0];
    else                    pos_next = sum[POS_W-2:0];
  end

  // Velocity is captured in DECODE, position integrated in UPDATE
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      inc_q <= 1'b0;
      pos   <= RESET_POS;
    end else begin
      if (decode) begin
        v_q   <= v_apply;
        inc_q <= inc;
      end
      if (update) pos <= pos_next;
    end
  end

  assign coord      = pos[FRAC_BITS +: COORD_W];
  assign coord_next = pos_next[FRAC_BITS +: COORD_W];

endmodule

// File: rtl/joystick_cursor.sv
// PmodJSTK cursor engine top: packet latch, IDLE->DECODE->UPDATE->DONE FSM,
// button edge detect, drop counter, and two joy_axis integrators.
// Build option: JOYSTICK_ACCEL_EN enables per-axis speed doubling after
// ACCEL_HOLD packets of sustained deflection.
//
// Handshake: valid is a one-cycle strobe with no back-pressure. A packet is
// accepted only in IDLE; a strobe in any other state is discarded and counted
// in drop_cnt. out_valid pulses for one cycle (in DONE) with fresh x/y/btn,
// and moved/btn_press are meaningful only while out_valid is high.
module joystick_cursor
  import joystick_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int FRAC_BITS   = 4,
  parameter int DEADZONE    = 32,
  parameter int SPEED_SHIFT = 3
`ifdef JOYSTICK_ACCEL_EN
  , parameter int ACCEL_HOLD = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [PKT_W-1:0]   data,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               out_valid,
  output logic               moved,
  output logic [BTN_W-1:0]   btn,
  output logic [BTN_W-1:0]   btn_press,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  logic [1:0]         state;
  logic [RAW_W-1:0]   raw_x_q;
  logic [RAW_W-1:0]   raw_y_q;
  logic [BTN_W-1:0]   btn_q;
  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic               decode;
  logic               update;

  // Reserved packet bits carry nothing for the cursor
  logic unused_bits;
  assign unused_bits = ^{data[31:26], data[15:10], data[7:3]};

  assign decode = (state == ST_DECODE);
  assign update = (state == ST_UPDATE);
  assign busy   = (state != ST_IDLE);

  // Sequencer: latch packet, step the axes, publish results in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      raw_x_q   <= RAW_W'(CENTER);
      raw_y_q   <= RAW_W'(CENTER);
      btn_q     <= '0;
      btn       <= '0;
      btn_press <= '0;
      out_valid <= 1'b0;
      moved     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      moved     <= 1'b0;
      btn_press <= '0;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            raw_x_q <= get_raw_x(data);
            raw_y_q <= get_raw_y(data);
            btn_q   <= data[BTN_LSB +: BTN_W];
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: state <= ST_UPDATE;
        ST_UPDATE: begin
          out_valid <= 1'b1;
          moved     <= (x_next != x) || (y_next != y);
          btn       <= btn_q;
          btn_press <= btn_q & ~btn;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of strobes that arrive while a packet is in flight
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (valid && busy && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
  end

  joy_axis #(
    .COORD_W     (COORD_W),
    .MAX         (X_MAX),
    .FRAC_BITS   (FRAC_BITS),
    .DEADZONE    (DEADZONE),
    .SPEED_SHIFT (SPEED_SHIFT),
`ifdef JOYSTICK_ACCEL_EN
    .ACCEL_HOLD  (ACCEL_HOLD),
`endif
    .INVERT      (1'b0)
  ) u_axis_x (
    .clk        (clk),
    .rst        (rst),
    .decode     (decode),
    .update     (update),
    .raw        (raw_x_q),
    .coord      (x),
    .coord_next (x_next)
  );

  joy_axis #(
    .COORD_W     (COORD_W),
    .MAX         (Y_MAX),
    .FRAC_BITS   (FRAC_BITS),
    .DEADZONE    (DEADZONE),
    .SPEED_SHIFT (SPEED_SHIFT),
`ifdef JOYSTICK_ACCEL_EN
    .ACCEL_HOLD  (ACCEL_HOLD),
`endif
    .INVERT      (1'b1)
  ) u_axis_y (
    .clk        (clk),
    .rst        (rst),
    .decode     (decode),
    .update     (update),
    .raw        (raw_y_q),
    .coord      (y),
    .coord_next (y_next)
  );

endmodule

// File: tb/tb_joystick_cursor.sv
// Bench for joystick_cursor: directed scenarios plus randomized packets,
// checked every cycle against a behavioural cursor model.
module tb_joystick_cursor;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [39:0] data;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        out_valid;
  logic        moved;
  logic [2:0]  btn;
  logic [2:0]  btn_press;
  logic        busy;
  logic [7:0]  drop_cnt;

  joystick_cursor dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .data      (data),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .moved     (moved),
    .btn       (btn),
    .btn_press (btn_press),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         due;
    int         ex;
    int         ey;
    bit         emoved;
    logic [2:0] ebtn;
    logic [2:0] epress;
  } exp_t;

  exp_t exp_q[$];

  localparam int XM = 639;
  localparam int YM = 479;
  localparam int SC = 16;

  int         cyc       = 0;
  bit         checking  = 0;
  int         busy_left = 0;
  int         px, py;
  int         mdrop;
  logic [2:0] mbtn;
  int         disp_x, disp_y;
  logic [2:0] disp_btn;
  int         ov_count  = 0;
  bit         last_moved;
  logic [2:0] last_press;
`ifdef JOYSTICK_ACCEL_EN
  int run_x, run_y, pdir_x, pdir_y;
`endif

  function automatic int speed(input int raw);
    int mag;
    mag = (raw >= 512) ? raw - 512 : 511 - raw;
    return (mag < 32) ? 0 : (mag - 32) / 8;
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    px = (XM / 2) * SC;  py = (YM / 2) * SC;
    disp_x = XM / 2;     disp_y = YM / 2;
    mbtn = 3'b000;       disp_btn = 3'b000;
    mdrop = 0;           busy_left = 0;
    exp_q.delete();
`ifdef JOYSTICK_ACCEL_EN
    run_x = 0; run_y = 0; pdir_x = 0; pdir_y = 0;
`endif
  endtask

  task automatic model_accept(input logic [39:0] d);
    int   rx, ry, vx, vy, dx, dy, nx, ny;
    exp_t e;
    rx = {d[25:24], d[39:32]};
    ry = {d[9:8], d[23:16]};
    vx = speed(rx);  vy = speed(ry);
    dx = (rx >= 512) ? 1 : -1;
    dy = (ry >= 512) ? -1 : 1;
`ifdef JOYSTICK_ACCEL_EN
    run_x = (vx == 0) ? 0 : ((run_x > 0 && dx == pdir_x) ? run_x + 1 : 1);
    run_y = (vy == 0) ? 0 : ((run_y > 0 && dy == pdir_y) ? run_y + 1 : 1);
    pdir_x = dx; pdir_y = dy;
    if (run_x > 16) vx = vx * 2;
    if (run_y > 16) vy = vy * 2;
`endif
    nx = clampi(px + dx * vx, XM * SC);
    ny = clampi(py + dy * vy, YM * SC);
    e.due    = cyc + 2;
    e.ex     = nx / SC;
    e.ey     = ny / SC;
    e.emoved = (nx / SC != px / SC) || (ny / SC != py / SC);
    e.ebtn   = d[2:0];
    e.epress = d[2:0] & ~mbtn;
    exp_q.push_back(e);
    px = nx; py = ny; mbtn = d[2:0];
  endtask

  // Model advances on each rising edge using the inputs held that cycle
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_reset();
      checking = 1;
    end else if (busy_left > 0) begin
      if (valid && mdrop < 255) mdrop++;
      busy_left--;
    end else if (valid) begin
      model_accept(data);
      busy_left = 3;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      bit   due_now;
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        disp_x = e.ex; disp_y = e.ey; disp_btn = e.ebtn;
      end
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_valid", out_valid, due_now);
      if (due_now) begin
        e = exp_q.pop_front();
        disp_x = e.ex; disp_y = e.ey; disp_btn = e.ebtn;
        if (out_valid) begin
          chk("moved", moved, e.emoved);
          chk("btn_press", btn_press, e.epress);
          ov_count++;
          last_moved = moved;
          last_press = btn_press;
        end
      end
      chk("x", x, disp_x);
      chk("y", y, disp_y);
      chk("btn", btn, disp_btn);
      chk("busy", busy, busy_left > 0);
      chk("drop_cnt", drop_cnt, mdrop);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int rx, input int ry, input int b);
    logic [39:0] d;
    d[31:0]  = $urandom();
    d[39:32] = 8'($urandom());
    d[39:32] = rx[7:0];
    d[25:24] = rx[9:8];
    d[23:16] = ry[7:0];
    d[9:8]   = ry[9:8];
    d[2:0]   = b[2:0];
    data = d;
  endtask

  task automatic send(input int rx, input int ry, input int b);
    set_pkt(rx, ry, b);
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic send_gap(input int rx, input int ry, input int b);
    send(rx, ry, b);
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ov0;
    rst = 1'b1; valid = 1'b0; data = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_x", x, 319);
    chk("rst_y", y, 239);
    chk("rst_btn", btn, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    tick();

    // Full right deflection: 59/16 px step
    send_gap(1023, 512, 0);
    chk("step_x", x, 322);
    chk("step_y", y, 239);
    chk("step_moved", last_moved, 1);

    // Inside deadzone
    ov0 = ov_count;
    send_gap(530, 500, 0);
    chk("dz_ov", ov_count - ov0, 1);
    chk("dz_moved", last_moved, 0);
    chk("dz_x", x, 322);

    // Button edge
    send_gap(512, 512, 0);
    send_gap(512, 512, 2);
    chk("press_edge", last_press, 3'b010);
    chk("press_btn", btn, 3'b010);
    send_gap(512, 512, 2);
    chk("press_hold", last_press, 3'b000);

    // Saturation at the corners
    for (int i = 0; i < 200; i++) send_gap(1023, 1023, 0);
    chk("sat_x", x, 639);
    chk("sat_y", y, 0);
    for (int i = 0; i < 200; i++) send_gap(0, 0, 0);
    chk("sat_x0", x, 0);
    chk("sat_ymax", y, 479);

    // Back-to-back strobes: one result, one drop
    ov0 = ov_count;
    set_pkt(1023, 512, 0);
    valid = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    repeat (4) tick();
    chk("b2b_ov", ov_count - ov0, 1);
    chk("b2b_drop", drop_cnt, 1);

    // Reset in mid-flight aborts the packet
    ov0 = ov_count;
    set_pkt(1023, 0, 5);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("abort_ov", ov_count - ov0, 0);
    chk("abort_x", x, 319);
    chk("abort_y", y, 239);
    chk("abort_drop", drop_cnt, 0);

    // Randomized traffic with drops and occasional reset collisions
    for (int i = 0; i < 500; i++) begin
      int sel, rx, ry;
      sel = $urandom_range(0, 3);
      rx = (sel == 0) ? $urandom_range(480, 544) : $urandom_range(0, 1023);
      ry = (sel == 1) ? $urandom_range(480, 544) : $urandom_range(0, 1023);
      if ($urandom_range(0, 49) == 0) begin
        set_pkt(rx, ry, $urandom_range(0, 7));
        rst = 1'b1; valid = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0;
      end else begin
        send(rx, ry, $urandom_range(0, 7));
      end
      repeat ($urandom_range(0, 5)) tick();
    end
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
